uart_bram_cmd_controller: RTL and testbench

Parametrised second-generation UART-to-BRAM command engine. It sits between the UART RX/TX cores and a single-port BRAM. It decodes addressed READ, WRITE and ERASE commands with a start address and length, and supports escape-stuffed write payloads. Every command ends with an ACK or NAK response byte.

---
 rtl/uart_bram_cmd_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_bram_cmd_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_bram_cmd_controller.sv
// rtl/uart_bram_cmd_controller.sv - UART-to-BRAM command engine (READ/WRITE/ERASE with ACK/NAK)
// Optional CHECKSUM_EN: XOR checksum of data bytes sent before ACK on READ and WRITE.
module uart_bram_cmd_controller #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 12,
    parameter int                    SIZE         = 4096,
    parameter logic [DATA_WIDTH-1:0] READ_CMD     = 8'h11,
    parameter logic [DATA_WIDTH-1:0] WRITE_CMD    = 8'h12,
    parameter logic [DATA_WIDTH-1:0] ERASE_CMD    = 8'h13,
    parameter logic [DATA_WIDTH-1:0] ESC_CHAR     = 8'h1B,
    parameter logic [DATA_WIDTH-1:0] ACK_CHAR     = 8'h06,
    parameter logic [DATA_WIDTH-1:0] NAK_CHAR     = 8'h15,
    parameter logic [DATA_WIDTH-1:0] ERASE_VALUE  = 8'h00,
    parameter int                    BRAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rx_done,
    input  logic                  tx_busy,
    input  logic [DATA_WIDTH-1:0] from_BRAM,
    output logic                  en,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] to_BRAM,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_WR_DATA, S_WR_ESC,
        S_RD_REQ, S_RD_WAIT, S_RD_SEND, S_RD_TX, S_ER_FILL, S_RESP, S_RESP_WAIT
    } state_t;

    state_t                state_q, state_n;
    logic                  rst_q, rx_prev, rx_rise, fin;
    logic [DATA_WIDTH-1:0] op_q, op_n, addr_hi_q, addr_hi_n, dout_q, dout_n;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_n, ptr_inc;
    logic [15:0]           len_q, len_n;
    logic [1:0]            lat_q, lat_n;
    logic                  seen_q, seen_n, ack_pend_q, ack_pend_n;
`ifdef CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_n;
`endif

    assign rx_rise = rx_done & ~rx_prev;
    assign ptr_inc = (32'(ptr_q) == SIZE - 1) ? '0 : ptr_q + 1'b1;
    assign addr    = ptr_q;
    assign dout    = dout_q;
    assign busy    = (state_q != S_IDLE);

    // Reset asserts asynchronously; rst_q holds it one extra cycle so release is clock-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_q <= 1'b0;
        else        rst_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !rst_q) begin
            state_q    <= S_IDLE;
            rx_prev    <= 1'b0;
            op_q       <= '0;
            addr_hi_q  <= '0;
            dout_q     <= '0;
            ptr_q      <= '0;
            len_q      <= '0;
            lat_q      <= '0;
            seen_q     <= 1'b0;
            ack_pend_q <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_n;
            rx_prev    <= rx_done;
            op_q       <= op_n;
            addr_hi_q  <= addr_hi_n;
            dout_q     <= dout_n;
            ptr_q      <= ptr_n;
            len_q      <= len_n;
            lat_q      <= lat_n;
            seen_q     <= seen_n;
            ack_pend_q <= ack_pend_n;
`ifdef CHECKSUM_EN
            csum_q     <= csum_n;
`endif
        end
    end

    always_comb begin
        state_n      = state_q;
        op_n         = op_q;
        addr_hi_n    = addr_hi_q;
        dout_n       = dout_q;
        ptr_n        = ptr_q;
        len_n        = len_q;
        lat_n        = lat_q;
        seen_n       = seen_q;
        ack_pend_n   = ack_pend_q;
`ifdef CHECKSUM_EN
        csum_n       = csum_q;
`endif
        en           = 1'b0;
        write_enable = 1'b0;
        to_BRAM      = '0;
        tx_start     = 1'b0;
        fin          = 1'b0;
        case (state_q)
            S_IDLE: if (rx_rise && din != ESC_CHAR) begin
                if (din == READ_CMD || din == WRITE_CMD || din == ERASE_CMD) begin
                    op_n    = din;
                    state_n = S_ADDR_HI;
`ifdef CHECKSUM_EN
                    csum_n  = '0;
`endif
                end else begin
                    dout_n     = NAK_CHAR;
                    ack_pend_n = 1'b0;
                    state_n    = S_RESP;
                end
            end
            S_ADDR_HI: if (rx_rise) begin
                addr_hi_n = din;
                state_n   = S_ADDR_LO;
            end
            S_ADDR_LO: if (rx_rise) begin
                ptr_n   = ADDR_WIDTH'(32'(ADDR_WIDTH'({addr_hi_q, din})) % SIZE);
                state_n = (op_q == WRITE_CMD) ? S_WR_DATA : S_LEN_HI;
            end
            S_LEN_HI: if (rx_rise) begin
                len_n   = {din, 8'h00};
                state_n = S_LEN_LO;
            end
            S_LEN_LO: if (rx_rise) begin
                len_n = {len_q[15:8], din};
                if ({len_q[15:8], din} == 16'd0) begin
                    if (op_q == READ_CMD) begin
                        fin = 1'b1;
                    end else begin
                        dout_n     = ACK_CHAR;
                        ack_pend_n = 1'b0;
                        state_n    = S_RESP;
                    end
                end else begin
                    state_n = (op_q == READ_CMD) ? S_RD_REQ : S_ER_FILL;
                end
            end
            S_WR_DATA: if (rx_rise) begin
                if (din == ESC_CHAR) begin
                    state_n = S_WR_ESC;
                end else begin
                    en           = 1'b1;
                    write_enable = 1'b1;
                    to_BRAM      = din;
                    ptr_n        = ptr_inc;
`ifdef CHECKSUM_EN
                    csum_n       = csum_q ^ din;
`endif
                end
            end
            S_WR_ESC: if (rx_rise) begin
                if (din == ESC_CHAR) begin
                    en           = 1'b1;
                    write_enable = 1'b1;
                    to_BRAM      = ESC_CHAR;
                    ptr_n        = ptr_inc;
                    state_n      = S_WR_DATA;
`ifdef CHECKSUM_EN
                    csum_n       = csum_q ^ ESC_CHAR;
`endif
                end else begin
                    fin = 1'b1;
                end
            end
            S_RD_REQ: begin
                en      = 1'b1;
                lat_n   = '0;
                state_n = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q == 2'(BRAM_LATENCY - 1)) begin
                    dout_n  = from_BRAM;
                    state_n = S_RD_SEND;
`ifdef CHECKSUM_EN
                    csum_n  = csum_q ^ from_BRAM;
`endif
                end else begin
                    lat_n = lat_q + 1'b1;
                end
            end
            S_RD_SEND, S_RESP: if (!tx_busy) begin
                tx_start = 1'b1;
                seen_n   = 1'b0;
                state_n  = (state_q == S_RD_SEND) ? S_RD_TX : S_RESP_WAIT;
            end
            S_RD_TX: begin
                if (tx_busy) seen_n = 1'b1;
                if (seen_q && !tx_busy) begin
                    len_n = len_q - 1'b1;
                    ptr_n = ptr_inc;
                    if (len_q == 16'd1) fin = 1'b1;
                    else                state_n = S_RD_REQ;
                end
            end
            S_ER_FILL: begin
                en           = 1'b1;
                write_enable = 1'b1;
                to_BRAM      = ERASE_VALUE;
                ptr_n        = ptr_inc;
                len_n        = len_q - 1'b1;
                if (len_q == 16'd1) begin
                    dout_n     = ACK_CHAR;
                    ack_pend_n = 1'b0;
                    state_n    = S_RESP;
                end
            end
            S_RESP_WAIT: begin
                if (tx_busy) seen_n = 1'b1;
                if (seen_q && !tx_busy) begin
                    if (ack_pend_q) begin
                        dout_n     = ACK_CHAR;
                        ack_pend_n = 1'b0;
                        state_n    = S_RESP;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Completed READ/WRITE: checksum byte (if enabled) goes out ahead of the ACK.
        if (fin) begin
            state_n    = S_RESP;
`ifdef CHECKSUM_EN
            dout_n     = csum_q;
            ack_pend_n = 1'b1;
`else
            dout_n     = ACK_CHAR;
            ack_pend_n = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_uart_bram_cmd_controller.sv
// tb/tb_uart_bram_cmd_controller.sv - directed self-checking bench for uart_bram_cmd_controller
module tb_uart_bram_cmd_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_busy;
    logic [7:0]  from_BRAM;
    logic        en, write_enable, tx_start, busy;
    logic [11:0] addr;
    logic [7:0]  to_BRAM, dout;

    always #5 clk = ~clk;

    uart_bram_cmd_controller dut (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_done(rx_done), .tx_busy(tx_busy),
        .from_BRAM(from_BRAM), .en(en), .write_enable(write_enable), .addr(addr),
        .to_BRAM(to_BRAM), .tx_start(tx_start), .dout(dout), .busy(busy)
    );

    // BRAM model (latency 1) and TX model (busy for 2 cycles per byte)
    logic [7:0] mem [0:4095];
    logic [7:0] rd_q = 8'h00;
    int         busy_cnt = 0;
    int         cyc = 0, en_cnt = 0, viol = 0;
    logic [7:0]  tx_q[$];
    logic [11:0] wr_a[$];
    logic [7:0]  wr_d[$];
    int          wr_c[$];

    assign from_BRAM = rd_q;
    assign tx_busy   = (busy_cnt != 0);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en) begin
            en_cnt <= en_cnt + 1;
            if (write_enable) begin
                mem[addr] <= to_BRAM;
                wr_a.push_back(addr);
                wr_d.push_back(to_BRAM);
                wr_c.push_back(cyc);
            end else begin
                rd_q <= mem[addr];
            end
        end
        if (tx_start) begin
            tx_q.push_back(dout);
            busy_cnt <= 2;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if ((tx_start && tx_busy) || (write_enable && !en)) viol <= viol + 1;
    end

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        din = b;
        rx_done = 1'b1;
        repeat (2) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Bytes are taken MSB-first from seq
    task automatic send_seq(input logic [63:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) send_byte(seq[8*i +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((busy || tx_busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 32'(k < 2000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_tx(input string tag, input int base, input logic [63:0] exp, input int n);
        check({tag, "_txlen"}, 32'(tx_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++)
            if (base + i < tx_q.size()) check({tag, "_tx"}, 32'(tx_q[base + i]), 32'(exp[8*(n-1-i) +: 8]));
    endtask

    initial begin
        int b, w, e, k;
        repeat (3) @(negedge clk);
        check("reset_outs", {en, write_enable, addr, to_BRAM, tx_start, dout, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: plain write
        b = tx_q.size(); w = wr_a.size();
        send_seq(64'h12_00_10_AA_BB_CC_1B_00, 8);
        wait_idle("t1");
        check("t1_wrcnt", 32'(wr_a.size() - w), 32'd3);
        check("t1_m10", 32'(mem[12'h010]), 32'hAA);
        check("t1_m11", 32'(mem[12'h011]), 32'hBB);
        check("t1_m12", 32'(mem[12'h012]), 32'hCC);
        check("t1_busy", 32'(busy), 32'd0);
`ifdef CHECKSUM_EN
        check_tx("t1", b, 64'hDD_06, 2);
`else
        check_tx("t1", b, 64'h06, 1);
`endif

        // 2: escaped payload
        b = tx_q.size(); w = wr_a.size();
        send_seq(64'h12_00_20_1B_1B_55_1B_00, 8);
        wait_idle("t2");
        check("t2_wrcnt", 32'(wr_a.size() - w), 32'd2);
        check("t2_m20", 32'(mem[12'h020]), 32'h1B);
        check("t2_m21", 32'(mem[12'h021]), 32'h55);
`ifdef CHECKSUM_EN
        check_tx("t2", b, 64'h4E_06, 2);
`else
        check_tx("t2", b, 64'h06, 1);
`endif

        // 3: read back test-1 data
        b = tx_q.size(); w = wr_a.size();
        send_seq(64'h11_00_10_00_03, 5);
        wait_idle("t3");
        check("t3_wrcnt", 32'(wr_a.size() - w), 32'd0);
`ifdef CHECKSUM_EN
        check_tx("t3", b, 64'hAA_BB_CC_DD_06, 5);
`else
        check_tx("t3", b, 64'hAA_BB_CC_06, 4);
`endif
        check("t3_viol", 32'(viol), 32'd0);

        // 4: erase with address wrap
        mem[12'hFFE] <= 8'h77; mem[12'hFFF] <= 8'h77;
        mem[12'h000] <= 8'h77; mem[12'h001] <= 8'h77;
        @(negedge clk);
        b = tx_q.size(); w = wr_a.size();
        send_seq(64'h13_0F_FE_00_04, 5);
        wait_idle("t4");
        check("t4_wrcnt", 32'(wr_a.size() - w), 32'd4);
        if (wr_a.size() - w == 4) begin
            check("t4_a0", 32'(wr_a[w]),     32'hFFE);
            check("t4_a1", 32'(wr_a[w + 1]), 32'hFFF);
            check("t4_a2", 32'(wr_a[w + 2]), 32'h000);
            check("t4_a3", 32'(wr_a[w + 3]), 32'h001);
            check("t4_d", {wr_d[w], wr_d[w + 1], wr_d[w + 2], wr_d[w + 3]}, 32'd0);
            check("t4_cyc", 32'(wr_c[w + 3] - wr_c[w]), 32'd3);
        end
        check("t4_mem", {mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]}, 32'd0);
        check_tx("t4", b, 64'h06, 1);

        // 5: unknown opcode, then a held rx_done
        b = tx_q.size(); e = en_cnt;
        send_byte(8'h7F);
        wait_idle("t5");
        check("t5_noaccess", 32'(en_cnt - e), 32'd0);
        check_tx("t5", b, 64'h15, 1);
        b = tx_q.size(); w = wr_a.size();
        din = 8'h12;
        rx_done = 1'b1;
        repeat (50) @(negedge clk);
        rx_done = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_hold_busy", 32'(busy), 32'd1);
        check("t5_hold_nowr", 32'(wr_a.size() - w), 32'd0);
        send_seq(64'h00_30_5A_1B_00, 5);
        wait_idle("t5b");
        check("t5_wrcnt", 32'(wr_a.size() - w), 32'd1);
        check("t5_m30", 32'(mem[12'h030]), 32'h5A);
`ifdef CHECKSUM_EN
        check_tx("t5b", b, 64'h5A_06, 2);
`else
        check_tx("t5b", b, 64'h06, 1);
`endif

        // 6: reset in the middle of a length-8 read
        b = tx_q.size();
        send_seq(64'h11_00_10_00_08, 5);
        k = 0;
        while (!(tx_q.size() >= b + 2 && en) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("t6_midread", 32'(k < 500), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("t6_reset_outs", {en, write_enable, addr, to_BRAM, tx_start, dout, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        wait_idle("t6_settle");
        b = tx_q.size(); w = wr_a.size();
        send_seq(64'h12_01_00_C3_1B_00, 6);
        wait_idle("t6");
        check("t6_wrcnt", 32'(wr_a.size() - w), 32'd1);
        check("t6_m100", 32'(mem[12'h100]), 32'hC3);
`ifdef CHECKSUM_EN
        check_tx("t6", b, 64'hC3_06, 2);
`else
        check_tx("t6", b, 64'h06, 1);
`endif
        check("viol_total", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
